// File: rtl/gpio_led_status.sv
// Power-on LED status sequencer: walks a 4-LED thermometer bar-graph, one step
// per STEP_CYCLES clocks, then lights led_done (optionally as a heartbeat).
module gpio_led_status #(
  parameter int STEP_CYCLES  = 20,
  parameter int HEARTBEAT_EN = 0,
  parameter int HB_CYCLES    = 50
) (
  input  logic clk,
  input  logic rst,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led_done
);

  localparam int SW = $clog2((STEP_CYCLES < 2) ? 2 : STEP_CYCLES);
  localparam int HW = $clog2((HB_CYCLES < 2) ? 2 : HB_CYCLES);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST   = HW'(HB_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, DONE} state_t;

  state_t        state;
  logic [SW-1:0] step_cnt;
  logic [HW-1:0] hb_cnt;

  // Outputs are set on the same edge as the state transition, so each LED
  // is a registered copy of "state has reached this step".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      hb_cnt   <= '0;
      led1     <= 1'b0;
      led2     <= 1'b0;
      led3     <= 1'b0;
      led4     <= 1'b0;
      led_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= S1;
          step_cnt <= '0;
          led1     <= 1'b1;
        end
        S1, S2, S3, S4: begin
          if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            case (state)
              S1:      begin state <= S2; led2 <= 1'b1; end
              S2:      begin state <= S3; led3 <= 1'b1; end
              S3:      begin state <= S4; led4 <= 1'b1; end
              default: begin state <= DONE; led_done <= 1'b1; hb_cnt <= '0; end
            endcase
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        DONE: begin
          if (HEARTBEAT_EN != 0) begin
            if (hb_cnt == HB_LAST) begin
              hb_cnt   <= '0;
              led_done <= ~led_done;
            end else begin
              hb_cnt <= hb_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          step_cnt <= '0;
          hb_cnt   <= '0;
          led1     <= 1'b0;
          led2     <= 1'b0;
          led3     <= 1'b0;
          led4     <= 1'b0;
          led_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_led_status.sv
// Scoreboard bench for gpio_led_status: three parameterisations share clk/rst and
// are compared every cycle against a closed-form timing model.
module tb_gpio_led_status;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic a1, a2, a3, a4, ad;
  logic b1, b2, b3, b4, bd;
  logic c1, c2, c3, c4, cd;

  gpio_led_status dut_dflt (
    .clk(clk), .rst(rst), .led1(a1), .led2(a2), .led3(a3), .led4(a4), .led_done(ad)
  );
  gpio_led_status #(.STEP_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .led1(b1), .led2(b2), .led3(b3), .led4(b4), .led_done(bd)
  );
  gpio_led_status #(.STEP_CYCLES(2), .HEARTBEAT_EN(1), .HB_CYCLES(4)) dut_hb (
    .clk(clk), .rst(rst), .led1(c1), .led2(c2), .led3(c3), .led4(c4), .led_done(cd)
  );

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  n           = 0;  // rising edges since the last reset release

  task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  // Expected {led1,led2,led3,led4,led_done} after edge e of the release.
  function automatic logic [4:0] model(input int e, input int s, input int hb_en, input int hb);
    logic [4:0] v;
    v = '0;
    if (e >= 1)       v[4] = 1'b1;
    if (e >= 1 + s)   v[3] = 1'b1;
    if (e >= 1 + 2*s) v[2] = 1'b1;
    if (e >= 1 + 3*s) v[1] = 1'b1;
    if (e >= 1 + 4*s) v[0] = (hb_en == 0) ? 1'b1 : (((e - 1 - 4*s) / hb) % 2 == 0);
    return v;
  endfunction

  task automatic push_exp();
    sb_t e;
    e.tag = "dflt"; e.exp = rst ? model(n, 20, 0, 1) : 5'b0; sb_q.push_back(e);
    e.tag = "s1";   e.exp = rst ? model(n, 1, 0, 1)  : 5'b0; sb_q.push_back(e);
    e.tag = "hb";   e.exp = rst ? model(n, 2, 1, 4)  : 5'b0; sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string ctx);
    sb_t e;
    logic [4:0] obs [3];
    obs[0] = {a1, a2, a3, a4, ad};
    obs[1] = {b1, b2, b3, b4, bd};
    obs[2] = {c1, c2, c3, c4, cd};
    for (int i = 0; i < 3; i++) begin
      if (sb_q.size() == 0) begin
        check_vec({ctx, "_sb_empty"}, 5'bx, 5'b0);
      end else begin
        e = sb_q.pop_front();
        check_vec({ctx, "_", e.tag}, obs[i], e.exp);
      end
    end
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    if (rst) n++;
    push_exp();
    #1;
    pop_cmp(ctx);
  endtask

  task automatic run(input string ctx, input int cycles);
    for (int i = 0; i < cycles; i++) step(ctx);
  endtask

  initial begin
    // Held in reset: everything stays dark.
    n = 0;
    run("reset_hold", 5);

    // Release between edges; nothing may change before edge 1.
    @(negedge clk); rst = 1'b1; n = 0;
    #1; push_exp(); pop_cmp("pre_edge1");
    run("seq_a", 30);

    // Asynchronous assert in state S2: outputs clear with no clock edge.
    #2; rst = 1'b0; n = 0;
    #1; push_exp(); pop_cmp("async_clr");
    run("reset_hold2", 2);
    @(negedge clk); rst = 1'b1; n = 0;
    run("seq_b", 120);

    // Sub-period glitch must still reset the whole sequence.
    @(negedge clk); rst = 1'b0; n = 0;
    #2; push_exp(); pop_cmp("glitch_clr");
    rst = 1'b1;
    run("seq_c", 100);

    // Long soak in DONE.
    run("soak", 10000);

    if (sb_q.size() != 0) check_vec("sb_leftover", 5'(sb_q.size()), 5'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
